// File: rtl/flux_tag_arbiter_if.sv
// flux_tag_arbiter_if: channel-side valid/ready handshake plus the shared
// multi-flux FIFO write port and per-flux read-event strobes.
// master = traffic source / FIFO side, slave = the arbiter.
interface flux_tag_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2
);
  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;

  logic [FLUX-1:0]                 in_valid;
  logic [FLUX*DATA_WIDTH-1:0]      in_data;
  logic [FLUX-1:0]                 in_ready;
  logic                            wr_en;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] wr_din;
  logic                            wr_full;
  logic [FLUX-1:0]                 rd_evt;

  modport master (
    output in_valid, in_data, wr_full, rd_evt,
    input  in_ready, wr_en, wr_din
  );

  modport slave (
    input  in_valid, in_data, wr_full, rd_evt,
    output in_ready, wr_en, wr_din
  );
endinterface

// File: rtl/flux_tag_arbiter.sv
// flux_tag_arbiter: round-robin arbiter feeding FLUX tagged channels into one
// shared multi-flux FIFO of DEPTH entries. Tracks FIFO occupancy (including the
// registered write still in flight) so grants never overrun the FIFO.
// Optional feature macro: FLUX_QUOTA_EN -- per-flux entry counters limit each
// flux to QUOTA entries in the FIFO. Default build (macro undefined) has no
// per-flux counters and gates only on wr_full and occupancy.
module flux_tag_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int DEPTH      = 4,
  parameter int QUOTA      = 2
) (
  input  logic              clk,
  input  logic              rst,
  flux_tag_arbiter_if.slave bus
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
  localparam logic [TAG_WIDTH-1:0] LAST_RST = TAG_WIDTH'(FLUX - 1);

  // Reject illegal configurations at elaboration time.
  generate
    if (FLUX < 2 || QUOTA < 1 || QUOTA > DEPTH) begin : g_param_check
      $error("flux_tag_arbiter: illegal FLUX/DEPTH/QUOTA combination");
    end
  endgenerate

  logic [CNT_WIDTH-1:0]            r_occ;
  logic [TAG_WIDTH-1:0]            r_last;
  logic                            r_wr_en;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] r_wr_din;

  logic [FLUX-1:0]       w_elig;
  logic [FLUX-1:0]       w_grant;
  logic [FLUX-1:0]       w_rd_ok;
  logic                  w_any;
  logic [TAG_WIDTH-1:0]  w_gidx;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [CNT_WIDTH-1:0]  w_occ_nxt;

`ifdef FLUX_QUOTA_EN
  logic [CNT_WIDTH-1:0] r_cnt [FLUX];
`endif

  // Eligibility uses only registered state, so reads raise it one cycle later.
  always_comb begin
    w_elig = '0;
    for (int f = 0; f < FLUX; f++) begin
`ifdef FLUX_QUOTA_EN
      w_elig[f] = !rst && bus.in_valid[f] && !bus.wr_full && (r_occ < DEPTH_C)
                  && (r_cnt[f] < CNT_WIDTH'(QUOTA));
`else
      w_elig[f] = !rst && bus.in_valid[f] && !bus.wr_full && (r_occ < DEPTH_C);
`endif
    end
  end

  // Round-robin pick: scan from last+1 with wrap, first eligible channel wins.
  always_comb begin
    int   v_idx;
    logic v_hit;
    w_grant = '0;
    w_gidx  = r_last;
    w_any   = 1'b0;
    v_idx   = 0;
    v_hit   = 1'b0;
    for (int k = 1; k <= FLUX; k++) begin
      v_idx          = ((int'(r_last) + k) >= FLUX) ? (int'(r_last) + k - FLUX)
                                                    : (int'(r_last) + k);
      v_hit          = !w_any && w_elig[v_idx];
      w_grant[v_idx] = v_hit;
      w_gidx         = v_hit ? TAG_WIDTH'(v_idx) : w_gidx;
      w_any          = w_any | v_hit;
    end
  end

  assign w_payload = bus.in_data[w_gidx*DATA_WIDTH +: DATA_WIDTH];

  // Net occupancy: count honoured reads (never more than held) against the grant.
  always_comb begin
    int v_num;
    v_num   = 0;
    w_rd_ok = '0;
    for (int f = 0; f < FLUX; f++) begin
`ifdef FLUX_QUOTA_EN
      w_rd_ok[f] = bus.rd_evt[f] && (r_cnt[f] != '0);
`else
      w_rd_ok[f] = bus.rd_evt[f];
`endif
      v_num = v_num + (w_rd_ok[f] ? 1 : 0);
    end
    v_num     = (v_num > int'(r_occ)) ? int'(r_occ) : v_num;
    w_occ_nxt = r_occ - CNT_WIDTH'(v_num) + {{(CNT_WIDTH-1){1'b0}}, w_any};
  end

  // Grant bookkeeping, occupancy and the registered one-cycle FIFO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ    <= '0;
      r_last   <= LAST_RST;
      r_wr_en  <= 1'b0;
      r_wr_din <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_wr_en <= w_any;
      if (w_any) begin
        r_last   <= w_gidx;
        r_wr_din <= {w_gidx, w_payload};
      end else begin
        r_last   <= r_last;
        r_wr_din <= r_wr_din;
      end
    end
  end

`ifdef FLUX_QUOTA_EN
  // Per-flux held-entry counters: +1 on grant, -1 on an honoured read.
  always_ff @(posedge clk) begin
    for (int f = 0; f < FLUX; f++) begin
      if (rst) begin
        r_cnt[f] <= '0;
      end else begin
        r_cnt[f] <= r_cnt[f] + {{(CNT_WIDTH-1){1'b0}}, w_grant[f]}
                             - {{(CNT_WIDTH-1){1'b0}}, w_rd_ok[f]};
      end
    end
  end
`endif

  // Reset masks the write port immediately so an in-flight write is dropped.
  assign bus.in_ready = w_grant;
  assign bus.wr_en    = r_wr_en & ~rst;
  assign bus.wr_din   = rst ? '0 : r_wr_din;

endmodule

// File: tb/tb_flux_tag_arbiter.sv
// tb_flux_tag_arbiter: scoreboard bench. The stimulus process drives inputs,
// predicts the grant from a per-flux occupancy model and queues the expected
// FIFO write; a separate monitor checks wr_en/wr_din one cycle later.
module tb_flux_tag_arbiter;
  localparam int DW    = 8;
  localparam int FLUX  = 2;
  localparam int DEPTH = 4;
  localparam int QUOTA = 2;
  localparam int TW    = $clog2(FLUX);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flux_tag_arbiter_if #(.DATA_WIDTH(DW), .FLUX(FLUX)) bus ();

  flux_tag_arbiter #(
    .DATA_WIDTH(DW), .FLUX(FLUX), .DEPTH(DEPTH), .QUOTA(QUOTA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // reference model: entries each flux holds in the FIFO (incl. in-flight write)
  int held [FLUX];
  int last_g;
  int prev_g;
  logic [TW+DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < FLUX; f++) held[f] = 0;
    last_g = FLUX - 1;
    prev_g = -1;
  endtask

  // one clock cycle of stimulus plus prediction
  task automatic step(input logic [FLUX-1:0] v, input logic full,
                      input logic [FLUX-1:0] rd, input logic r);
    logic [FLUX*DW-1:0] data;
    logic [FLUX-1:0]    exp_ready;
    int total;
    int g;
    @(posedge clk);
    #1;
    for (int f = 0; f < FLUX; f++) data[f*DW +: DW] = DW'($urandom());
    if (r) exp_q.delete();
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = data;
    bus.wr_full  = full;
    bus.rd_evt   = rd;
    #3;
    total = 0;
    for (int f = 0; f < FLUX; f++) total += held[f];
    g = -1;
    if (!r && !full && total < DEPTH) begin
      for (int k = 1; k <= FLUX; k++) begin
        int c;
        c = (last_g + k) % FLUX;
`ifdef FLUX_QUOTA_EN
        if (g < 0 && v[c] && held[c] < QUOTA) g = c;
`else
        if (g < 0 && v[c]) g = c;
`endif
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    if (r) begin
      model_reset();
    end else begin
      for (int f = 0; f < FLUX; f++)
        if (rd[f] && held[f] > 0) held[f]--;
      if (g >= 0) begin
        held[g]++;
        last_g = g;
        exp_q.push_back({TW'(g), data[g*DW +: DW]});
      end
      prev_g = g;
    end
  endtask

  // monitor: each cycle the DUT must present exactly the queued write, else hold wr_din
  initial begin
    logic [TW+DW-1:0] hold_din;
    logic [TW+DW-1:0] e;
    logic             want;
    hold_din = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        check("rst_wr_en", 64'(bus.wr_en), 64'(0));
        check("rst_wr_din", 64'(bus.wr_din), 64'(0));
        hold_din = '0;
      end else begin
        want = (exp_q.size() > 0);
        check("wr_en", 64'(bus.wr_en), 64'(want));
        if (want) begin
          e = exp_q.pop_front();
          check("wr_din", 64'(bus.wr_din), 64'(e));
          hold_din = e;
        end else begin
          check("wr_din_hold", 64'(bus.wr_din), 64'(hold_din));
        end
      end
    end
  end

  initial begin
    logic [FLUX-1:0] rd;
    logic [FLUX-1:0] v;
    logic            r;
    model_reset();
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.wr_full  = 1'b0;
    bus.rd_evt   = '0;

    repeat (3) step(2'b00, 1'b0, 2'b00, 1'b1);        // reset state
    repeat (6) step(2'b11, 1'b0, 2'b00, 1'b0);        // fill: 0,1,0,1 then stall
    step(2'b11, 1'b0, 2'b01, 1'b0);                   // read at full: no grant now
    repeat (2) step(2'b11, 1'b0, 2'b00, 1'b0);        // one grant next cycle
    repeat (2) step(2'b00, 1'b0, 2'b11, 1'b0);        // drain
    repeat (3) step(2'b11, 1'b1, 2'b00, 1'b0);        // wr_full blocks
    step(2'b11, 1'b0, 2'b00, 1'b0);                   // resumes at flux 1
    step(2'b11, 1'b0, 2'b00, 1'b0);                   // grant to flux 0
    step(2'b11, 1'b0, 2'b00, 1'b1);                   // reset drops pending write
    step(2'b00, 1'b0, 2'b00, 1'b1);
    step(2'b11, 1'b0, 2'b00, 1'b0);                   // flux 0 first after reset
    step(2'b00, 1'b0, 2'b00, 1'b1);
    repeat (2) step(2'b00, 1'b0, 2'b11, 1'b0);        // reads at empty ignored
    repeat (6) step(2'b01, 1'b0, 2'b00, 1'b0);        // single flux: quota or depth limit
    step(2'b01, 1'b0, 2'b01, 1'b0);                   // one read frees one slot
    repeat (2) step(2'b01, 1'b0, 2'b00, 1'b0);

    // randomized traffic; reads only for entries already written to the FIFO
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      v = FLUX'($urandom());
      for (int f = 0; f < FLUX; f++) begin
        int avail;
        avail = held[f] - ((prev_g == f) ? 1 : 0);
        rd[f] = (avail > 0) && ($urandom_range(0, 1) == 1);
      end
      step(v, ($urandom_range(0, 7) == 0), rd, r);
    end

    step(2'b00, 1'b0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
